// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared constants for the Fermat prime search engine
//
// Contents:
//   MODE_SEARCH / MODE_CHECK  values of the mode input
//   BASE_TABLE                Fermat bases, used in order up to NUM_BASES
//   state_t / ST_*            top-level FSM encoding
//   lfsr_taps()               Galois feedback masks indexed by register width
package prime_pkg;

    localparam logic MODE_SEARCH = 1'b0;
    localparam logic MODE_CHECK  = 1'b1;

    localparam logic [7:0] BASE_TABLE [0:7] = '{
        8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19
    };

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRAW   = 3'd1;
    localparam state_t ST_SCREEN = 3'd2;
    localparam state_t ST_EXP    = 3'd3;
    localparam state_t ST_CHECK  = 3'd4;
    localparam state_t ST_REPORT = 3'd5;
    localparam state_t ST_FAIL   = 3'd6;

    // Right-shifting Galois masks: bit (t-1) is set for every polynomial tap t.
    // Widths missing from the table fall back to a two-tap mask that keeps the
    // register moving but is not guaranteed to be maximal length.
    function automatic logic [127:0] lfsr_taps(input int w);
        logic [127:0] t;
        t = '0;
        case (w)
            8:       t[7:0]   = 8'hB8;
            12:      t[11:0]  = 12'h829;
            16:      t[15:0]  = 16'hD008;
            24:      t[23:0]  = 24'hE10000;
            32:      t[31:0]  = 32'h80200003;
            48:      t[47:0]  = 48'hC000_0018_0000;
            64:      t[63:0]  = 64'hD800_0000_0000_0000;
            128: begin
                t[127] = 1'b1;
                t[125] = 1'b1;
                t[100] = 1'b1;
                t[98]  = 1'b1;
            end
            default: begin
                if (w >= 2 && w <= 128) begin
                    t[7'(w - 1)] = 1'b1;
                    t[7'(w - 2)] = 1'b1;
                end
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mod_exp_seq.sv
// rtl/mod_exp_seq.sv - sequential modular exponentiation r = base^exponent mod modulus
//
// Right-to-left square-and-multiply. Each modular product is an interleaved
// shift-add-subtract taking WIDTH cycles, one multiplier bit per cycle.
// base must already be below modulus, and modulus must be greater than 1.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   go        in   start pulse, accepted while idle; operands latched
//   base      in   WIDTH   base
//   exponent  in   WIDTH   exponent
//   modulus   in   WIDTH   modulus
//   ready     out  one-cycle pulse, r valid
//   r         out  WIDTH   result, held until the next ready
module mod_exp_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             ready,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_PICK = 2'd1;
    localparam logic [1:0] M_RUN  = 2'd2;

    logic [1:0]       st;
    logic             op_sqr;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] m_x;
    logic [WIDTH+1:0] t1;
    logic [WIDTH+1:0] t1r;
    logic [WIDTH+1:0] t2;
    logic [WIDTH+1:0] t2r;

    // One interleaved step: acc = (2*acc + a_bit*b) mod m. acc and b are both
    // below m, so one conditional subtract after each half keeps acc < m and
    // the sum never exceeds WIDTH+2 bits.
    always_comb begin
        m_x = {2'b00, m_q};
        t1  = acc << 1;
        t1r = (t1 >= m_x) ? t1 - m_x : t1;
        t2  = t1r + (mul_a[WIDTH-1] ? {2'b00, mul_b} : '0);
        t2r = (t2 >= m_x) ? t2 - m_x : t2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st     <= M_IDLE;
            op_sqr <= 1'b0;
            res_q  <= '0;
            b_q    <= '0;
            e_q    <= '0;
            m_q    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            cnt    <= '0;
            acc    <= '0;
            ready  <= 1'b0;
            r      <= '0;
        end else begin
            ready <= 1'b0;
            case (st)
                M_IDLE: begin
                    if (go) begin
                        res_q <= WIDTH'(1);
                        b_q   <= base;
                        e_q   <= exponent;
                        m_q   <= modulus;
                        st    <= M_PICK;
                    end
                end
                M_PICK: begin
                    if (e_q == '0) begin
                        r     <= res_q;
                        ready <= 1'b1;
                        st    <= M_IDLE;
                    end else begin
                        // A set exponent bit multiplies into the result first;
                        // the square of the running base always follows.
                        acc    <= '0;
                        cnt    <= '0;
                        op_sqr <= ~e_q[0];
                        mul_a  <= e_q[0] ? res_q : b_q;
                        mul_b  <= b_q;
                        st     <= M_RUN;
                    end
                end
                M_RUN: begin
                    acc   <= t2r;
                    mul_a <= mul_a << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        acc <= '0;
                        cnt <= '0;
                        if (!op_sqr) begin
                            res_q  <= t2r[WIDTH-1:0];
                            op_sqr <= 1'b1;
                            mul_a  <= b_q;
                            mul_b  <= b_q;
                        end else begin
                            b_q <= t2r[WIDTH-1:0];
                            e_q <= e_q >> 1;
                            st  <= M_PICK;
                        end
                    end
                end
                default: st <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prime_search_engine.sv
// rtl/prime_search_engine.sv - sequential Fermat prime search / check engine
//
// SEARCH draws random odd WIDTH-bit candidates (MSB forced) from a free-running
// Galois LFSR and returns the first one passing NUM_BASES Fermat tests, or
// pulses fail after MAX_ATTEMPTS rejections. CHECK tests the supplied n_in.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   request, accepted only while busy is low
//   mode      in   0 = SEARCH, 1 = CHECK; sampled with start
//   n_in      in   WIDTH  CHECK candidate; sampled with start
//   busy      out  high from the cycle after accept until done/fail
//   done      out  one-cycle pulse, result/is_prime valid
//   fail      out  one-cycle pulse, SEARCH ran out of attempts
//   is_prime  out  verdict for result
//   result    out  WIDTH  tested or found number (0 on fail)
//   attempts  out  candidates rejected in the last SEARCH
module prime_search_engine
    import prime_pkg::*;
#(
    parameter int          WIDTH        = 64,
    parameter int          NUM_BASES    = 4,
    parameter int          MAX_ATTEMPTS = 1024,
    parameter logic [63:0] SEED         = 64'hABCDEFABCDEF1234
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              mode,
    input  logic [WIDTH-1:0]                  n_in,
    output logic                              busy,
    output logic                              done,
    output logic                              fail,
    output logic                              is_prime,
    output logic [WIDTH-1:0]                  result,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts
);

    localparam int               AW        = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [WIDTH-1:0] SEED_W    = WIDTH'({((WIDTH + 63) / 64){SEED}});
    localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] DRAW_MASK = {1'b1, {(WIDTH - 2){1'b0}}, 1'b1};
    localparam logic [3:0]       NB4       = 4'(NUM_BASES);

    state_t           state;
    logic             mode_q;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] lfsr;
    logic [2:0]       k;
    logic             verdict;
    logic             exp_started;
    logic             r_ok;
    logic [WIDTH-1:0] base_w;
    logic             skip;
    logic             go;
    logic             ready_m;
    logic [WIDTH-1:0] r_m;
    logic [AW-1:0]    att_next;
    logic             last_try;

    always_comb begin
        base_w   = WIDTH'(BASE_TABLE[k]);
        skip     = (base_w >= cand);
        go       = (state == ST_EXP) && !exp_started && !skip;
        att_next = attempts + 1'b1;
        last_try = (att_next == AW'(MAX_ATTEMPTS));
    end

    mod_exp_seq #(
        .WIDTH (WIDTH)
    ) u_mod_exp (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go),
        .base     (base_w),
        .exponent (cand - WIDTH'(1)),
        .modulus  (cand),
        .ready    (ready_m),
        .r        (r_m)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED_W;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            is_prime    <= 1'b0;
            result      <= '0;
            attempts    <= '0;
            mode_q      <= MODE_SEARCH;
            cand        <= '0;
            k           <= '0;
            verdict     <= 1'b0;
            exp_started <= 1'b0;
            r_ok        <= 1'b0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        mode_q   <= mode;
                        is_prime <= 1'b0;
                        result   <= '0;
                        k        <= '0;
                        if (mode == MODE_CHECK) begin
                            cand  <= n_in;
                            state <= ST_SCREEN;
                        end else begin
                            attempts <= '0;
                            state    <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    cand  <= lfsr | DRAW_MASK;
                    k     <= '0;
                    state <= ST_SCREEN;
                end
                ST_SCREEN: begin
                    if (cand == WIDTH'(2) || cand == WIDTH'(3)) begin
                        verdict <= 1'b1;
                        state   <= ST_REPORT;
                    end else if (cand < WIDTH'(2) || !cand[0]) begin
                        if (mode_q == MODE_CHECK) begin
                            verdict <= 1'b0;
                            state   <= ST_REPORT;
                        end else begin
                            attempts <= att_next;
                            state    <= last_try ? ST_FAIL : ST_DRAW;
                        end
                    end else begin
                        exp_started <= 1'b0;
                        state       <= ST_EXP;
                    end
                end
                ST_EXP: begin
                    // A base not below the candidate carries no information.
                    if (skip) begin
                        r_ok  <= 1'b1;
                        state <= ST_CHECK;
                    end else if (!exp_started) begin
                        exp_started <= 1'b1;
                    end else if (ready_m) begin
                        exp_started <= 1'b0;
                        r_ok        <= (r_m == WIDTH'(1));
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!r_ok) begin
                        if (mode_q == MODE_CHECK) begin
                            verdict <= 1'b0;
                            state   <= ST_REPORT;
                        end else begin
                            attempts <= att_next;
                            state    <= last_try ? ST_FAIL : ST_DRAW;
                        end
                    end else if ({1'b0, k} + 4'd1 == NB4) begin
                        verdict <= 1'b1;
                        state   <= ST_REPORT;
                    end else begin
                        k     <= k + 1'b1;
                        state <= ST_EXP;
                    end
                end
                ST_REPORT: begin
                    result   <= cand;
                    is_prime <= verdict;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                ST_FAIL: begin
                    result   <= '0;
                    is_prime <= 1'b0;
                    fail     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_search_engine.sv
// tb/tb_prime_search_engine.sv - scoreboard bench for prime_search_engine
module tb_prime_search_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // u_a: WIDTH 16, 4 bases; u_b: 1 base; u_c: 2 bases (all CHECK)
    logic        a_start, a_mode, a_busy, a_done, a_fail, a_isp;
    logic [15:0] a_n, a_res;
    logic [10:0] a_att;
    logic        b_start, b_mode, b_busy, b_done, b_fail, b_isp;
    logic [15:0] b_n, b_res;
    logic [10:0] b_att;
    logic        c_start, c_mode, c_busy, c_done, c_fail, c_isp;
    logic [15:0] c_n, c_res;
    logic [10:0] c_att;
    // u_d: WIDTH 8 SEARCH, 1024 attempts; u_e: WIDTH 8 SEARCH, 1 attempt
    logic        d_start, d_mode, d_busy, d_done, d_fail, d_isp;
    logic [7:0]  d_n, d_res;
    logic [10:0] d_att;
    logic        e_start, e_mode, e_busy, e_done, e_fail, e_isp;
    logic [7:0]  e_n, e_res;
    logic [0:0]  e_att;

    prime_search_engine #(.WIDTH(16), .NUM_BASES(4), .MAX_ATTEMPTS(1024)) u_a (
        .clk(clk), .reset_n(rst_n), .start(a_start), .mode(a_mode), .n_in(a_n), .busy(a_busy),
        .done(a_done), .fail(a_fail), .is_prime(a_isp), .result(a_res), .attempts(a_att));
    prime_search_engine #(.WIDTH(16), .NUM_BASES(1), .MAX_ATTEMPTS(1024)) u_b (
        .clk(clk), .reset_n(rst_n), .start(b_start), .mode(b_mode), .n_in(b_n), .busy(b_busy),
        .done(b_done), .fail(b_fail), .is_prime(b_isp), .result(b_res), .attempts(b_att));
    prime_search_engine #(.WIDTH(16), .NUM_BASES(2), .MAX_ATTEMPTS(1024)) u_c (
        .clk(clk), .reset_n(rst_n), .start(c_start), .mode(c_mode), .n_in(c_n), .busy(c_busy),
        .done(c_done), .fail(c_fail), .is_prime(c_isp), .result(c_res), .attempts(c_att));
    prime_search_engine #(.WIDTH(8), .NUM_BASES(4), .MAX_ATTEMPTS(1024)) u_d (
        .clk(clk), .reset_n(rst_n), .start(d_start), .mode(d_mode), .n_in(d_n), .busy(d_busy),
        .done(d_done), .fail(d_fail), .is_prime(d_isp), .result(d_res), .attempts(d_att));
    prime_search_engine #(.WIDTH(8), .NUM_BASES(4), .MAX_ATTEMPTS(1), .SEED(64'h0000_0000_0000_00A7)) u_e (
        .clk(clk), .reset_n(rst_n), .start(e_start), .mode(e_mode), .n_in(e_n), .busy(e_busy),
        .done(e_done), .fail(e_fail), .is_prime(e_isp), .result(e_res), .attempts(e_att));

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit     isp;
        longint res;
    } exp_t;

    exp_t q16[3][$];
    int   pend[2];
    int   fails_seen[2];

    localparam int BASES [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    localparam int LIMIT   = 3000;
    localparam int LIMIT_S = 20000;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Fermat verdict from first principles: b^(n-1) by repeated multiplication.
    function automatic bit fermat_ref(input longint n, input int nb);
        longint p;
        if (n < 2) return 1'b0;
        if (n == 2 || n == 3) return 1'b1;
        if (n % 2 == 0) return 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (BASES[i] >= n) continue;
            p = 1;
            for (longint j = 0; j < n - 1; j++) p = (p * BASES[i]) % n;
            if (p != 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int nb_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 2;
    endfunction

    // ---------------- monitors ----------------
    task automatic mon16(input int i, input logic dn, input logic fl, input logic isp, input logic [15:0] res);
        exp_t x;
        if (dn) begin
            chk($sformatf("u%0d_done_expected", i), longint'(q16[i].size() > 0), 1);
            if (q16[i].size() > 0) begin
                x = q16[i].pop_front();
                chk($sformatf("u%0d_is_prime_n%0d", i, x.res), longint'(isp), longint'(x.isp));
                chk($sformatf("u%0d_result", i), longint'(res), x.res);
            end
        end
        if (fl) chk($sformatf("u%0d_no_fail_in_check", i), longint'(fl), 0);
    endtask

    task automatic mon_s(input int i, input logic dn, input logic fl, input logic isp,
                         input logic [7:0] res, input int att, input int maxa);
        if (dn || fl) begin
            chk($sformatf("s%0d_response_expected", i), longint'(pend[i] > 0), 1);
            if (pend[i] > 0) pend[i]--;
        end
        if (dn) begin
            chk($sformatf("s%0d_result_odd_in_range", i),
                longint'(res >= 8'd129 && res[0] == 1'b1), 1);
            chk($sformatf("s%0d_result_prime_%0d", i, res), longint'(fermat_ref(longint'(res), 4)), 1);
            chk($sformatf("s%0d_is_prime", i), longint'(isp), 1);
            chk($sformatf("s%0d_attempts_below_max", i), longint'(att < maxa), 1);
        end
        if (fl) begin
            fails_seen[i]++;
            chk($sformatf("s%0d_fail_attempts", i), att, maxa);
            chk($sformatf("s%0d_fail_result", i), longint'(res), 0);
            chk($sformatf("s%0d_fail_is_prime", i), longint'(isp), 0);
        end
    endtask

    always @(negedge clk) begin
        mon16(0, a_done, a_fail, a_isp, a_res);
        mon16(1, b_done, b_fail, b_isp, b_res);
        mon16(2, c_done, c_fail, c_isp, c_res);
        mon_s(0, d_done, d_fail, d_isp, d_res, int'(d_att), 1024);
        mon_s(1, e_done, e_fail, e_isp, e_res, int'(e_att), 1);
    end

    // ---------------- drivers ----------------
    task automatic drive16(input int i, input logic s, input logic [15:0] n);
        case (i)
            0:       begin a_start = s; a_mode = 1'b1; a_n = n; end
            1:       begin b_start = s; b_mode = 1'b1; b_n = n; end
            default: begin c_start = s; c_mode = 1'b1; c_n = n; end
        endcase
    endtask

    function automatic logic fin16(input int i);
        case (i)
            0:       return a_done | a_fail;
            1:       return b_done | b_fail;
            default: return c_done | c_fail;
        endcase
    endfunction

    task automatic run_check(input int i, input logic [15:0] n, input bit hold, output int cyc);
        exp_t x;
        x.isp = fermat_ref(longint'(n), nb_of(i));
        x.res = longint'(n);
        q16[i].push_back(x);
        drive16(i, 1'b1, n);
        @(negedge clk);
        cyc = 1;
        if (!hold) drive16(i, 1'b0, n);
        while (!fin16(i) && cyc < LIMIT) begin
            if (hold) drive16(i, 1'b1, 16'($urandom));
            @(negedge clk);
            cyc++;
        end
        drive16(i, 1'b0, n);
        chk($sformatf("u%0d_finished_n%0d", i, n), longint'(cyc < LIMIT), 1);
    endtask

    task automatic run_search(input int i, output int cyc);
        pend[i]++;
        if (i == 0) d_start = 1'b1; else e_start = 1'b1;
        @(negedge clk);
        cyc = 1;
        d_start = 1'b0;
        e_start = 1'b0;
        while (!((i == 0) ? (d_done | d_fail) : (e_done | e_fail)) && cyc < LIMIT_S) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("s%0d_search_finished", i), longint'(cyc < LIMIT_S), 1);
    endtask

    initial begin
        int cyc;
        logic [15:0] rn;
        int dir [12] = '{65521, 1000, 2, 1, 5, 561, 29341, 0, 3, 4, 9, 65535};

        a_start = 0; a_mode = 0; a_n = 0;
        b_start = 0; b_mode = 0; b_n = 0;
        c_start = 0; c_mode = 0; c_n = 0;
        d_start = 0; d_mode = 0; d_n = 0;
        e_start = 0; e_mode = 0; e_n = 0;
        pend[0] = 0; pend[1] = 0;
        fails_seen[0] = 0; fails_seen[1] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", longint'(a_busy), 0);
        chk("reset_done", longint'(a_done), 0);
        chk("reset_fail", longint'(a_fail), 0);
        chk("reset_is_prime", longint'(a_isp), 0);
        chk("reset_result", longint'(a_res), 0);
        chk("reset_attempts", longint'(a_att), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed CHECK cases, with latency bounds on the prime and the early exit
        foreach (dir[j]) begin
            run_check(0, 16'(dir[j]), 1'b0, cyc);
            if (dir[j] == 1000) chk("latency_1000", longint'(cyc <= 4), 1);
            if (dir[j] == 65521) chk("latency_65521", longint'(cyc <= 4 * 2 * 16 * 18 + 4), 1);
            @(negedge clk);
        end

        // base-count sensitivity on the base-2 pseudoprime
        run_check(1, 16'd341, 1'b0, cyc);
        run_check(2, 16'd341, 1'b0, cyc);
        run_check(1, 16'd1105, 1'b0, cyc);

        // random CHECKs, half forced odd
        for (int j = 0; j < 10; j++) begin
            rn = 16'($urandom_range(0, 65535));
            if (j % 2 == 0) rn[0] = 1'b1;
            run_check(0, rn, 1'b0, cyc);
            @(negedge clk);
        end

        // SEARCH with room to find a prime
        for (int j = 0; j < 3; j++) begin
            run_search(0, cyc);
            repeat ($urandom_range(1, 7)) @(negedge clk);
        end

        // SEARCH with a single attempt: composite draws must fail
        for (int j = 0; j < 12; j++) begin
            run_search(1, cyc);
            repeat ($urandom_range(1, 9)) @(negedge clk);
        end
        chk("single_attempt_fail_seen", longint'(fails_seen[1] > 0), 1);

        // start held high throughout the run, including the done edge
        run_check(0, 16'd97, 1'b1, cyc);
        repeat (4) @(negedge clk);
        chk("start_while_busy_ignored", longint'(a_busy), 0);

        // reset in the middle of exponentiation
        run_check(0, 16'd2, 1'b0, cyc);
        drive16(0, 1'b1, 16'd65521);
        q16[0].push_back('{isp: 1'b1, res: 65521});
        @(negedge clk);
        drive16(0, 1'b0, 16'd0);
        repeat (60) @(negedge clk);
        chk("busy_before_abort", longint'(a_busy), 1);
        rst_n = 1'b0;
        q16[0].delete();
        @(negedge clk);
        chk("abort_busy", longint'(a_busy), 0);
        chk("abort_done", longint'(a_done), 0);
        chk("abort_result", longint'(a_res), 0);
        chk("abort_is_prime", longint'(a_isp), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_check(0, 16'd1000, 1'b0, cyc);
        run_check(0, 16'd13, 1'b0, cyc);
        repeat (3) @(negedge clk);

        chk("queue_a_drained", longint'(q16[0].size()), 0);
        chk("queue_b_drained", longint'(q16[1].size()), 0);
        chk("queue_c_drained", longint'(q16[2].size()), 0);
        chk("search_d_drained", longint'(pend[0]), 0);
        chk("search_e_drained", longint'(pend[1]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
